alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential signed ALU: single-cycle arithmetic/logic/shift/compare ops plus
// iterative shift-add multiply and restoring divide driven by a small FSM.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] d_hi,
  output logic             o,
  output logic             z,
  output logic             n,
  output logic             cond,
  output logic             dz
);

  localparam logic [4:0] OP_ZERO = 5'b00000;
  localparam logic [4:0] OP_A    = 5'b00001;
  localparam logic [4:0] OP_B    = 5'b00010;
  localparam logic [4:0] OP_INC  = 5'b00011;
  localparam logic [4:0] OP_DEC  = 5'b00100;
  localparam logic [4:0] OP_ADD  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b00111;
  localparam logic [4:0] OP_EQ   = 5'b01000;
  localparam logic [4:0] OP_LT   = 5'b01001;
  localparam logic [4:0] OP_GT   = 5'b01010;
  localparam logic [4:0] OP_NOT  = 5'b01011;
  localparam logic [4:0] OP_NEG  = 5'b01100;
  localparam logic [4:0] OP_AND  = 5'b01101;
  localparam logic [4:0] OP_OR   = 5'b01110;
  localparam logic [4:0] OP_XOR  = 5'b01111;
  localparam logic [4:0] OP_LSL  = 5'b10000;
  localparam logic [4:0] OP_LSR  = 5'b10001;
  localparam logic [4:0] OP_ASR  = 5'b10010;
  localparam logic [4:0] OP_ROL  = 5'b10011;
  localparam logic [4:0] OP_ROR  = 5'b10100;
  localparam logic [4:0] OP_DIV  = 5'b10101;

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t state, nxt_state;
  logic [CW-1:0] cnt;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] r);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] r);
    return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [SHW-1:0] sh_amt;
  int             rot_amt;
  logic           accept, div0, multi, last_iter;

  assign a_s       = a_in;
  assign b_s       = b_in;
  assign sh_amt    = b_in[SHW-1:0];
  assign rot_amt   = int'(sh_amt) % WIDTH;
  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign div0      = (opcode == OP_DIV) && (b_in == '0);
  assign multi     = (opcode == OP_MUL) || ((opcode == OP_DIV) && !div0);
  assign last_iter = ((state == MUL) || (state == DIV)) && (cnt == CW'(WIDTH-1));

  // Single-cycle result path, driven straight from the request inputs
  logic [WIDTH-1:0] sc_lo, sc_hi;
  logic             sc_o, sc_cond, sc_cond_we, sc_cmp, sc_dz;

  always_comb begin
    sc_lo      = '0;
    sc_hi      = '0;
    sc_o       = 1'b0;
    sc_cond    = 1'b0;
    sc_cond_we = 1'b0;
    sc_cmp     = 1'b0;
    sc_dz      = 1'b0;
    case (opcode)
      OP_ZERO: sc_lo = '0;
      OP_A:    sc_lo = a_in;
      OP_B:    sc_lo = b_in;
      OP_INC: begin
        sc_lo = a_in + ONE;
        sc_o  = (a_in == MAX_VAL);
      end
      OP_DEC: begin
        sc_lo = a_in - ONE;
        sc_o  = (a_in == MIN_VAL);
      end
      OP_ADD: begin
        sc_lo = a_in + b_in;
        sc_o  = add_ovf(a_in, b_in, sc_lo);
      end
      OP_SUB: begin
        sc_lo = a_in - b_in;
        sc_o  = sub_ovf(a_in, b_in, sc_lo);
      end
      OP_EQ: begin
        sc_cmp = 1'b1; sc_cond_we = 1'b1; sc_cond = (a_s == b_s);
      end
      OP_LT: begin
        sc_cmp = 1'b1; sc_cond_we = 1'b1; sc_cond = (a_s < b_s);
      end
      OP_GT: begin
        sc_cmp = 1'b1; sc_cond_we = 1'b1; sc_cond = (a_s > b_s);
      end
      OP_NOT:  sc_lo = ~a_in;
      OP_NEG: begin
        sc_lo = -a_in;
        sc_o  = (a_in == MIN_VAL);
      end
      OP_AND:  sc_lo = a_in & b_in;
      OP_OR:   sc_lo = a_in | b_in;
      OP_XOR:  sc_lo = a_in ^ b_in;
      OP_LSL:  sc_lo = a_in << sh_amt;
      OP_LSR:  sc_lo = a_in >> sh_amt;
      OP_ASR:  sc_lo = a_s >>> sh_amt;
      // A zero rotate shifts the complementary term by WIDTH, which yields 0
      OP_ROL:  sc_lo = (a_in << rot_amt) | (a_in >> (WIDTH - rot_amt));
      OP_ROR:  sc_lo = (a_in >> rot_amt) | (a_in << (WIDTH - rot_amt));
      OP_DIV: begin
        sc_dz = 1'b1;
        sc_hi = a_in;
      end
      OP_MUL:  sc_lo = '0;
      default: begin
        sc_cond_we = 1'b1;
        sc_cond    = 1'b0;
      end
    endcase
  end

  // Iteration registers: MUL keeps {partial, multiplier}, DIV keeps {remainder, dividend/quotient}
  logic [WIDTH:0]   work_hi_p0;
  logic [WIDTH-1:0] work_lo_p0, opnd_p0;
  logic             neg_q_p0, neg_r_p0;

  logic [WIDTH:0]     mul_sum, mul_acc, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_shift;
  logic               div_ge;

  assign mul_sum   = work_hi_p0 + {1'b0, opnd_p0};
  assign mul_acc   = work_lo_p0[0] ? mul_sum : work_hi_p0;
  assign mul_shift = {mul_acc, work_lo_p0[WIDTH-1:1]};
  assign div_sh    = {work_hi_p0[WIDTH-1:0], work_lo_p0[WIDTH-1]};
  assign div_ge    = (div_sh >= {1'b0, opnd_p0});
  assign div_diff  = div_sh - {1'b0, opnd_p0};

  // Final result formed from the last iteration's combinational values
  logic [WIDTH-1:0]   fin_lo, fin_hi, quo_mag, rem_mag;
  logic [2*WIDTH-1:0] prod_s;
  logic               fin_o;

  always_comb begin
    fin_lo  = '0;
    fin_hi  = '0;
    fin_o   = 1'b0;
    quo_mag = '0;
    rem_mag = '0;
    prod_s  = '0;
    if (state == DIV) begin
      quo_mag = {work_lo_p0[WIDTH-2:0], div_ge};
      rem_mag = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      fin_lo  = neg_q_p0 ? -quo_mag : quo_mag;
      fin_hi  = neg_r_p0 ? -rem_mag : rem_mag;
      fin_o   = !neg_q_p0 && quo_mag[WIDTH-1];
    end else begin
      prod_s = neg_q_p0 ? -mul_shift : mul_shift;
      fin_lo = prod_s[WIDTH-1:0];
      fin_hi = prod_s[2*WIDTH-1:WIDTH];
      fin_o  = (fin_hi != {WIDTH{fin_lo[WIDTH-1]}});
    end
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE: begin
        if (accept && (opcode == OP_MUL))
          nxt_state = MUL;
        else if (accept && (opcode == OP_DIV) && !div0)
          nxt_state = DIV;
      end
      MUL, DIV: if (last_iter) nxt_state = FIN;
      FIN:      nxt_state = IDLE;
      default:  nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      if (accept)
        cnt <= '0;
      else if ((state == MUL) || (state == DIV))
        cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      work_hi_p0 <= '0;
      neg_q_p0   <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
      neg_r_p0   <= a_in[WIDTH-1];
      if (opcode == OP_DIV) begin
        work_lo_p0 <= mag(a_in);
        opnd_p0    <= mag(b_in);
      end else begin
        work_lo_p0 <= mag(b_in);
        opnd_p0    <= mag(a_in);
      end
    end else if (state == MUL) begin
      work_hi_p0 <= {1'b0, mul_shift[2*WIDTH-1:WIDTH]};
      work_lo_p0 <= mul_shift[WIDTH-1:0];
    end else if (state == DIV) begin
      work_hi_p0 <= div_ge ? div_diff : div_sh;
      work_lo_p0 <= {work_lo_p0[WIDTH-2:0], div_ge};
    end
  end

  // Result registers: written at acceptance for 1-cycle ops, on the last iteration otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      d_out     <= '0;
      d_hi      <= '0;
      o         <= 1'b0;
      z         <= 1'b1;
      n         <= 1'b0;
      cond      <= 1'b0;
      dz        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !multi) begin
        out_valid <= 1'b1;
        dz        <= sc_dz;
        if (sc_cond_we) cond <= sc_cond;
        if (!sc_cmp) begin
          d_out <= sc_lo;
          d_hi  <= sc_hi;
          o     <= sc_o;
          z     <= (sc_lo == '0);
          n     <= sc_lo[WIDTH-1];
        end
      end else if (last_iter) begin
        out_valid <= 1'b1;
        dz        <= 1'b0;
        d_out     <= fin_lo;
        d_hi      <= fin_hi;
        o         <= fin_o;
        z         <= (fin_lo == '0);
        n         <= fin_lo[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq: every result is compared against an
// integer-arithmetic model of the operation set, plus directed corner cases.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready;
  logic [4:0]   opcode;
  logic [W-1:0] a_in, b_in, d_out, d_hi;
  logic         out_valid, o, z, n, cond, dz;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] e_lo, e_hi;
  logic         e_o, e_cond, e_dz;
  int           e_lat;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a_in(a_in), .b_in(b_in), .out_valid(out_valid),
    .d_out(d_out), .d_hi(d_hi), .o(o), .z(z), .n(n), .cond(cond), .dz(dz)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain signed integer arithmetic on 64-bit values
  task automatic model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, r, q, mx, mn;
    int sh;
    bit ar;
    logic [W-1:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    mx = (longint'(1) << (W-1)) - 1;
    mn = -mx - 1;
    sh = int'(b[$clog2(W)-1:0]);
    e_lat = 1;
    e_dz  = 1'b0;
    ar    = 1'b0;
    r     = 0;
    case (op)
      5'd0:  begin e_lo = '0;    e_hi = '0; e_o = 1'b0; end
      5'd1:  begin e_lo = a;     e_hi = '0; e_o = 1'b0; end
      5'd2:  begin e_lo = b;     e_hi = '0; e_o = 1'b0; end
      5'd3:  begin r = sa + 1;   ar = 1'b1; end
      5'd4:  begin r = sa - 1;   ar = 1'b1; end
      5'd5:  begin r = sa + sb;  ar = 1'b1; end
      5'd6:  begin r = sa - sb;  ar = 1'b1; end
      5'd7: begin
        r     = sa * sb;
        e_lo  = r[W-1:0];
        e_hi  = r[2*W-1:W];
        e_o   = (r > mx) || (r < mn);
        e_lat = W + 1;
      end
      5'd8:  e_cond = (sa == sb);
      5'd9:  e_cond = (sa < sb);
      5'd10: e_cond = (sa > sb);
      5'd11: begin e_lo = ~a;    e_hi = '0; e_o = 1'b0; end
      5'd12: begin r = -sa;      ar = 1'b1; end
      5'd13: begin e_lo = a & b; e_hi = '0; e_o = 1'b0; end
      5'd14: begin e_lo = a | b; e_hi = '0; e_o = 1'b0; end
      5'd15: begin e_lo = a ^ b; e_hi = '0; e_o = 1'b0; end
      5'd16: begin r = longint'(a) << sh;  e_lo = r[W-1:0]; e_hi = '0; e_o = 1'b0; end
      5'd17: begin r = longint'(a) >> sh;  e_lo = r[W-1:0]; e_hi = '0; e_o = 1'b0; end
      5'd18: begin r = sa >>> sh;          e_lo = r[W-1:0]; e_hi = '0; e_o = 1'b0; end
      5'd19: begin
        t = a;
        repeat (sh % W) t = {t[W-2:0], t[W-1]};
        e_lo = t; e_hi = '0; e_o = 1'b0;
      end
      5'd20: begin
        t = a;
        repeat (sh % W) t = {t[0], t[W-1:1]};
        e_lo = t; e_hi = '0; e_o = 1'b0;
      end
      5'd21: begin
        if (sb == 0) begin
          e_dz = 1'b1; e_lo = '0; e_hi = a; e_o = 1'b0;
        end else begin
          q     = sa / sb;
          r     = sa % sb;
          e_lo  = q[W-1:0];
          e_hi  = r[W-1:0];
          e_o   = (q > mx);
          e_lat = W + 1;
        end
      end
      default: begin e_lo = '0; e_hi = '0; e_o = 1'b0; e_cond = 1'b0; end
    endcase
    if (ar) begin
      e_lo = r[W-1:0];
      e_hi = '0;
      e_o  = (r > mx) || (r < mn);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ovld"}, out_valid, 1'b0);
    chk({tag, "_rdy"},  in_ready,  1'b1);
    chk({tag, "_dout"}, d_out,     '0);
    chk({tag, "_dhi"},  d_hi,      '0);
    chk({tag, "_flags"}, {o, z, n, cond, dz}, 5'b01000);
  endtask

  // Issue one request, scramble inputs after acceptance, check latency and outputs
  task automatic run_op(input string tag, input logic [4:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    int  lat;
    bit  rdy_seen;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, 1'b1);
    opcode   = op;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    model(op, a, b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode   = 5'($urandom);
    a_in     = W'($urandom);
    b_in     = W'($urandom);
    lat      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 64) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"},  lat,      e_lat);
    chk({tag, "_busy"}, rdy_seen, 1'b0);
    chk({tag, "_dout"}, d_out,    e_lo);
    chk({tag, "_dhi"},  d_hi,     e_hi);
    chk({tag, "_flags"}, {o, z, n, cond, dz},
        {e_o, (e_lo == '0), e_lo[W-1], e_cond, e_dz});
    @(posedge clk); #1;
    chk({tag, "_pulse"}, out_valid, 1'b0);
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0: return {1'b1, {(W-1){1'b0}}};
      1: return {1'b0, {(W-1){1'b1}}};
      2: return '1;
      3: return '0;
      4: return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; in_valid = 1'b1; opcode = 5'd5; a_in = 16'h0001; b_in = 16'h0001;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    e_lo = '0; e_hi = '0; e_o = 1'b0; e_cond = 1'b0; e_dz = 1'b0;

    run_op("add_ovf",  5'd5,  16'h7FFF, 16'h0001);
    run_op("mul_neg",  5'd7,  16'hFFFD, 16'h0007);
    run_op("div_neg",  5'd21, 16'hFFF9, 16'h0002);
    run_op("div_min",  5'd21, 16'h8000, 16'hFFFF);
    run_op("neg_min",  5'd12, 16'h8000, 16'h0000);
    run_op("sub_ovf",  5'd6,  16'h8000, 16'h0001);
    run_op("ror",      5'd20, 16'h0001, 16'h0004);
    run_op("rol_wrap", 5'd19, 16'h8001, 16'hFFF3);
    run_op("lsl_zero", 5'd16, 16'hA5A5, 16'h0010);
    run_op("asr",      5'd18, 16'h8000, 16'h0003);
    run_op("cmp_lt",   5'd9,  16'hFFFF, 16'h0001);
    run_op("undef",    5'd22, 16'h1234, 16'h5678);
    run_op("cmp_lt2",  5'd9,  16'hFFFF, 16'h0001);
    run_op("div_zero", 5'd21, 16'h0005, 16'h0000);

    // MUL with a second request held on in_valid for the whole operation
    @(negedge clk);
    opcode = 5'd7; a_in = 16'h0100; b_in = 16'h0100; in_valid = 1'b1;
    model(5'd7, 16'h0100, 16'h0100);
    @(posedge clk); #1;
    opcode = 5'd5; a_in = 16'h1234; b_in = 16'h0011;
    cnt = 1;
    while (!out_valid && cnt < 64) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("mul_hold_lat", cnt, W + 1);
    chk("mul_hold_res", {d_hi, d_out}, 32'h0001_0000);
    chk("mul_hold_flags", {o, z, n}, 3'b110);
    model(5'd5, 16'h1234, 16'h0011);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!out_valid && cnt < 8);
    in_valid = 1'b0;
    chk("held_add_res", d_out, 16'h1245);
    chk("held_add_flags", {o, z, n, dz}, 4'b0000);
    @(posedge clk); #1;
    chk("held_add_pulse", out_valid, 1'b0);

    // Reset in the middle of a divide
    run_op("div_zero2", 5'd21, 16'h0005, 16'h0000);
    @(negedge clk);
    opcode = 5'd21; a_in = 16'h7FFF; b_in = 16'h0003; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_vals("div_abort");
    cnt = 0;
    repeat (24) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("div_abort_quiet", cnt, 0);
    e_lo = '0; e_hi = '0; e_o = 1'b0; e_cond = 1'b0; e_dz = 1'b0;
    run_op("add_after", 5'd5, 16'h0003, 16'h0004);

    for (int i = 0; i < 200; i++) begin
      logic [4:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 5'($urandom_range(0, 31));
      ra  = pick_val();
      rb  = ($urandom_range(0, 5) == 0) ? '0 : pick_val();
      run_op("rnd", rop, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
